// File: rtl/ieee_sp_to_flopoco.sv
// IEEE-754 single precision to FloPoCo (wE=8, wF=23) converter, two-stage
// valid/ready pipeline with a saturating count of subnormals flushed to zero.
module ieee_sp_to_flopoco #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [33:0]      R,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] flush_cnt
);

    // Handshake: a word moves on a clk edge where valid and ready are both 1.
    // Stage 1 advances whenever stage 2 is empty or is being emptied, which
    // makes in_ready combinational from out_ready and removes bubbles.
    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [22:0] s1_frac;
    logic        s1_exp_zero;
    logic        s1_exp_ones;
    logic        s1_frac_zero;
    logic        s1_frac_msb;

    logic        s2_valid;
    logic [33:0] r_q;

    logic        s1_adv;
    logic [33:0] r_next;
    logic        s1_flush;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign R         = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exp       <= 8'd0;
            s1_frac      <= 23'd0;
            s1_exp_zero  <= 1'b0;
            s1_exp_ones  <= 1'b0;
            s1_frac_zero <= 1'b0;
            s1_frac_msb  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign      <= X[31];
                s1_exp       <= X[30:23];
                s1_frac      <= X[22:0];
                s1_exp_zero  <= (X[30:23] == 8'h00);
                s1_exp_ones  <= (X[30:23] == 8'hFF);
                s1_frac_zero <= (X[22:0] == 23'd0);
                s1_frac_msb  <= X[22];
            end
        end
    end

    // Subnormals with the leading fraction bit set fit as exponent 0 with the
    // fraction shifted left once; smaller ones fall below the range and flush.
    always_comb begin
        r_next   = {2'b01, s1_sign, s1_exp, s1_frac};
        s1_flush = 1'b0;
        if (s1_exp_ones) begin
            if (!s1_frac_zero) begin
                r_next = {2'b11, 32'd0};
            end else begin
                r_next = {2'b10, s1_sign, 31'd0};
            end
        end else if (s1_exp_zero) begin
            if (s1_frac_zero) begin
                r_next = {2'b00, s1_sign, 31'd0};
            end else if (s1_frac_msb) begin
                r_next = {2'b01, s1_sign, 8'h00, s1_frac[21:0], 1'b0};
            end else begin
                r_next   = {2'b00, s1_sign, 31'd0};
                s1_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            r_q      <= 34'd0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_q <= r_next;
            end
        end
    end

    // Counted on the single edge a flushed word enters stage 2, so stalls
    // cannot count it twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (s1_adv && s1_valid && s1_flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
